// File: rtl/mux_arb_param_pkg.sv
// Shared constants for the registered N:1 mux/arbiter.
// Mode encodings and output FSM states.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/mux_arb_param_if.sv
// Data/handshake bundle between producers, the mux and the consumer.
// slave = mux side, master = environment side.
interface mux_arb_param_if #(
    parameter  int WIDTH    = 2,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
);

    logic [WIDTH*CHANNELS-1:0] data_in;
    logic [CHANNELS-1:0]       valid_in;
    logic                      ready_out;
    logic [WIDTH-1:0]          data_out;
    logic                      valid_out;
    logic [SEL_W-1:0]          sel_out;
    logic [CHANNELS-1:0]       pop;

    modport slave (
        input  data_in,
        input  valid_in,
        input  ready_out,
        output data_out,
        output valid_out,
        output sel_out,
        output pop
    );

    modport master (
        output data_in,
        output valid_in,
        output ready_out,
        input  data_out,
        input  valid_out,
        input  sel_out,
        input  pop
    );

endinterface

// File: rtl/mux_arb_param_rr_arbiter.sv
// Combinational round-robin search: first request after 'last',
// wrapping modulo CHANNELS.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last,
    output logic [CHANNELS-1:0] grant_oh,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                any
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = SEL_W'((int'(last) + k) % CHANNELS);
            if (!any && req[idx]) begin
                any            = 1'b1;
                grant_idx      = idx;
                grant_oh[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_param.sv
// Registered N:1 mux with selector or round-robin grant and a
// single-entry output register under a valid/ready handshake.
module mux_arb_param
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 2,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             mode,
    input  logic [SEL_W-1:0] selector,
    mux_arb_param_if.slave   bus
);

    localparam int NPOW = 1 << SEL_W;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;

    logic [CHANNELS-1:0] rr_oh;
    logic [SEL_W-1:0]    rr_idx;
    logic                rr_any;

    logic [NPOW-1:0]     valid_ext;
    logic                load;
    logic                grant;
    logic                take;
    logic [CHANNELS-1:0] g_oh;
    logic [SEL_W-1:0]    g_idx;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_rr (
        .req       (bus.valid_in),
        .last      (last_q),
        .grant_oh  (rr_oh),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    // Padding to a power of two makes out-of-range selectors read as idle.
    always_comb begin
        valid_ext = NPOW'(bus.valid_in);
        load      = (state_q == ST_EMPTY) || bus.ready_out;
        g_oh      = '0;
        g_idx     = '0;
        grant     = 1'b0;
        if (mode == MODE_RR) begin
            g_oh  = rr_oh;
            g_idx = rr_idx;
            grant = rr_any;
        end else if (valid_ext[selector]) begin
            g_idx = selector;
            grant = 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                g_oh[i] = (SEL_W'(i) == selector);
            end
        end
        take = grant && load && reset_L;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        last_d  = last_q;
        if (load) begin
            if (take) begin
                state_d = ST_FULL;
                data_d  = bus.data_in[int'(g_idx)*WIDTH +: WIDTH];
                sel_d   = g_idx;
                if (mode == MODE_RR) begin
                    last_d = g_idx;
                end
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            last_q  <= SEL_W'(CHANNELS - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = (state_q == ST_FULL);
    assign bus.sel_out   = sel_q;
    assign bus.pop       = take ? g_oh : '0;

endmodule

// File: tb/tb_mux_arb_param.sv
// Directed bench with a scoreboard queue; a negedge monitor checks
// every word the consumer accepts.
module tb_mux_arb_param;

    logic       clk;
    logic       reset_L;
    logic       mode;
    logic [1:0] selector;

    mux_arb_param_if #(.WIDTH(2), .CHANNELS(4)) bus ();

    mux_arb_param #(.WIDTH(2), .CHANNELS(4)) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .mode     (mode),
        .selector (selector),
        .bus      (bus)
    );

    typedef struct {
        logic [1:0] d;
        logic [1:0] s;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Accepted words are compared against the scoreboard head.
    always @(negedge clk) begin
        if (bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
            exp_t e;
            if (q.size() == 0) begin
                chk("sb_unexpected_word", 8'd1, 8'd0);
            end else begin
                e = q.pop_front();
                chk("sb_data", {6'd0, bus.data_out}, {6'd0, e.d});
                chk("sb_sel", {6'd0, bus.sel_out}, {6'd0, e.s});
            end
        end
    end

    // Drive one cycle; inputs change 1 time unit after posedge.
    task automatic cyc(input string nm, input logic rst, input logic md,
                       input logic [1:0] sel, input logic [7:0] din,
                       input logic [3:0] vin, input logic rdy,
                       input logic [3:0] ep, input bit eg,
                       input logic [1:0] ed, input logic [1:0] es);
        exp_t e;
        reset_L      = rst;
        mode         = md;
        selector     = sel;
        bus.data_in  = din;
        bus.valid_in = vin;
        bus.ready_out = rdy;
        if (eg) begin
            e.d = ed;
            e.s = es;
            q.push_back(e);
        end
        @(negedge clk);
        chk({nm, "_pop"}, {4'd0, bus.pop}, {4'd0, ep});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_L = 1'b0;
        mode = 1'b0;
        selector = 2'd0;
        bus.data_in = 8'hFF;
        bus.valid_in = 4'hF;
        bus.ready_out = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        cyc("rst0", 0, 0, 0, 8'hFF, 4'hF, 1, 4'h0, 0, 0, 0);
        cyc("rst1", 0, 0, 0, 8'hFF, 4'hF, 1, 4'h0, 0, 0, 0);
        chk("rst_data", {6'd0, bus.data_out}, 8'd0);
        chk("rst_valid", {7'd0, bus.valid_out}, 8'd0);
        chk("rst_sel", {6'd0, bus.sel_out}, 8'd0);

        // Selector mode
        cyc("sel2", 1, 0, 2, 8'h30, 4'b0100, 1, 4'b0100, 1, 2'b11, 2);
        chk("sel2_valid", {7'd0, bus.valid_out}, 8'd1);
        cyc("sel3", 1, 0, 3, 8'h30, 4'b0100, 1, 4'b0000, 0, 0, 0);
        chk("sel3_valid", {7'd0, bus.valid_out}, 8'd0);
        chk("sel3_hold_data", {6'd0, bus.data_out}, 8'd3);
        chk("sel3_hold_sel", {6'd0, bus.sel_out}, 8'd2);

        // Round-robin, all valid
        cyc("rr0", 1, 1, 0, 8'hE4, 4'hF, 1, 4'b0001, 1, 0, 0);
        cyc("rr1", 1, 1, 0, 8'hE4, 4'hF, 1, 4'b0010, 1, 1, 1);
        cyc("rr2", 1, 1, 0, 8'hE4, 4'hF, 1, 4'b0100, 1, 2, 2);
        cyc("rr3", 1, 1, 0, 8'hE4, 4'hF, 1, 4'b1000, 1, 3, 3);
        cyc("rr4", 1, 1, 0, 8'hE4, 4'hF, 1, 4'b0001, 1, 0, 0);

        // Round-robin, sparse with wrap
        cyc("sp0", 1, 1, 0, 8'hE4, 4'b1010, 1, 4'b0010, 1, 1, 1);
        cyc("sp1", 1, 1, 0, 8'hE4, 4'b1010, 1, 4'b1000, 1, 3, 3);
        cyc("sp2", 1, 1, 0, 8'hE4, 4'b1010, 1, 4'b0010, 1, 1, 1);
        cyc("sp3", 1, 1, 0, 8'hE4, 4'b1010, 1, 4'b1000, 1, 3, 3);

        // Backpressure: output holds the ch3 word, pointer frozen
        cyc("st0", 1, 1, 0, 8'hE4, 4'hF, 0, 4'b0000, 0, 0, 0);
        chk("st0_data", {6'd0, bus.data_out}, 8'd3);
        chk("st0_sel", {6'd0, bus.sel_out}, 8'd3);
        cyc("st1", 1, 1, 0, 8'hE4, 4'b0001, 0, 4'b0000, 0, 0, 0);
        chk("st1_valid", {7'd0, bus.valid_out}, 8'd1);
        chk("st1_data", {6'd0, bus.data_out}, 8'd3);
        cyc("st2", 1, 1, 0, 8'hE4, 4'hF, 0, 4'b0000, 0, 0, 0);
        chk("st2_sel", {6'd0, bus.sel_out}, 8'd3);
        cyc("go0", 1, 1, 0, 8'hE4, 4'hF, 1, 4'b0001, 1, 0, 0);

        // Mid-stream reset at last=2
        cyc("pre1", 1, 1, 0, 8'hE4, 4'hF, 1, 4'b0010, 1, 1, 1);
        cyc("pre2", 1, 1, 0, 8'hE4, 4'hF, 1, 4'b0100, 1, 2, 2);
        cyc("mrst", 0, 1, 0, 8'hE4, 4'hF, 1, 4'b0000, 0, 0, 0);
        chk("mrst_valid", {7'd0, bus.valid_out}, 8'd0);
        chk("mrst_data", {6'd0, bus.data_out}, 8'd0);
        chk("mrst_sel", {6'd0, bus.sel_out}, 8'd0);
        cyc("post0", 1, 1, 0, 8'hE4, 4'hF, 1, 4'b0001, 1, 0, 0);
        cyc("drain", 1, 1, 0, 8'hE4, 4'h0, 1, 4'b0000, 0, 0, 0);
        chk("drain_valid", {7'd0, bus.valid_out}, 8'd0);
        chk("sb_leftover", 8'(q.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
